ripple_add_sequencer: RTL and testbench

- Control stage that wraps a chain of WIDTH one-bit registered full-adder stages. In that chain, carry ripples one stage per clock.
- Accepts word operands over a valid/ready handshake and drives the chain's a/b/carry-in lines.
- Holds the operands stable until the chain has settled, then captures the sum and carry-out.
- Presents the result over an output valid/ready handshake, with an accumulate mode that feeds the last result back in as operand b.

---
 rtl/ripple_add_pkg.sv | 20 ++
 rtl/ripple_add_sequencer_if.sv | 36 +++
 rtl/ripple_add_sequencer_chain.sv | 31 +++
 rtl/ripple_add_sequencer.sv | 92 +++++++++
 tb/tb_ripple_add_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ripple_add_pkg.sv
// Shared types and helpers for the ripple-add sequencer.
// Holds the FSM encoding, default width and settle-time helper.
package ripple_add_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int settle_cycles(
    input int w,
    input int e
  );
    return w + e;
  endfunction

endpackage

// File: rtl/ripple_add_sequencer_if.sv
// Request/result handshake bundle for the ripple-add sequencer.
// master = requester/consumer side, slave = sequencer side.
interface ripple_add_sequencer_if
  import ripple_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_acc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b,
    output in_cin, in_acc, out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_cin, in_acc, out_ready,
    output in_ready, out_valid,
    output out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ripple_add_sequencer_chain.sv
// Chain of WIDTH registered 1-bit full adders.
// Carry advances one stage per clock; no reset by design.
module ripple_add_sequencer_chain
  import ripple_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_co
);

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_co;
  logic [WIDTH-1:0] w_cin;

  assign w_cin = {r_co[WIDTH-2:0], i_ci};

  always_ff @(posedge clk) begin
    r_sum <= i_a ^ i_b ^ w_cin;
    r_co  <= (i_a & i_b) | (i_a & w_cin) |
             (i_b & w_cin);
  end

  assign o_sum = r_sum;
  assign o_co  = r_co;

endmodule

// File: rtl/ripple_add_sequencer.sv
// Sequencer driving a registered ripple-carry chain: holds
// operands for the full settle time, then captures the result.
module ripple_add_sequencer
  import ripple_add_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int EXTRA_SETTLE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ripple_add_sequencer_if.slave bus,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_ci,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic [WIDTH-1:0]      add_co
);

  localparam int SETTLE = settle_cycles(WIDTH, EXTRA_SETTLE);
  localparam int CW     = $clog2(SETTLE + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ci;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_capture;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_capture = (r_state == RUN) &&
                     (r_cnt == CW'(SETTLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_next = RUN;
      RUN:     if (w_capture)     w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operands stay frozen outside IDLE so the chain sees one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_ci   <= 1'b0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_acc ? r_acc : bus.in_b;
        r_ci  <= bus.in_cin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_sum  <= add_sum;
        r_cout <= add_co[WIDTH-1];
        r_ovf  <= add_co[WIDTH-1] ^ add_co[WIDTH-2];
        r_acc  <= add_sum;
      end
    end
  end

  assign add_a         = r_a;
  assign add_b         = r_b;
  assign add_ci        = r_ci;
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Randomized bench for ripple_add_sequencer with the adder chain
// alongside; results compared against plain integer arithmetic.
module tb_ripple_add_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ci;
  logic [W-1:0] add_sum;
  logic [W-1:0] add_co;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_acc;
  logic [W-1:0] e_sum;
  logic         e_cout;
  logic         e_ovf;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;

  ripple_add_sequencer_if #(.WIDTH(W)) bus ();

  ripple_add_sequencer #(
    .WIDTH(W),
    .EXTRA_SETTLE(0)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_ci  (add_ci),
    .add_sum (add_sum),
    .add_co  (add_co)
  );

  ripple_add_sequencer_chain #(.WIDTH(W)) u_chain (
    .clk   (clk),
    .i_a   (add_a),
    .i_b   (add_b),
    .i_ci  (add_ci),
    .o_sum (add_sum),
    .o_co  (add_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected result from plain integer arithmetic.
  task automatic model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         accm
  );
    int ua, ub, sa, sb, us, ss;
    e_a = a;
    e_b = accm ? m_acc : b;
    ua  = int'(e_a);
    ub  = int'(e_b);
    sa  = e_a[W-1] ? ua - (1 << W) : ua;
    sb  = e_b[W-1] ? ub - (1 << W) : ub;
    us  = ua + ub + int'(cin);
    ss  = sa + sb + int'(cin);
    e_sum  = W'(us);
    e_cout = (us >= (1 << W));
    e_ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
  endtask

  task automatic drive(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         accm
  );
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_acc   = accm;
  endtask

  // Returns at the negedge inside cycle 0 of the new operation.
  task automatic send(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         accm
  );
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("rdy_timeout", 0, 1);
    model(a, b, cin, accm);
    drive(a, b, cin, accm);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("op_a", add_a, e_a);
    chk("op_b", add_b, e_b);
    chk("op_rdy", bus.in_ready, 0);
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("latency", n, 5);
    chk("sum", bus.out_sum, e_sum);
    chk("cout", bus.out_cout, e_cout);
    chk("ovf", bus.out_ovf, e_ovf);
    m_acc = e_sum;
  endtask

  task automatic release_res(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_sum", bus.out_sum, e_sum);
      chk("bp_cout", bus.out_cout, e_cout);
      chk("bp_rdy", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", bus.out_valid, 0);
    chk("rel_rdy", bus.in_ready, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         accm,
    input int           hold
  );
    send(a, b, cin, accm);
    wait_res();
    release_res(hold);
  endtask

  initial begin
    rst_n         = 1'b0;
    m_acc         = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_acc    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_cout", bus.out_cout, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_ci", add_ci, 0);
    rst_n = 1'b1;

    op(4'd3, 4'd5, 1'b0, 1'b0, 0);
    chk("basic_ovf", bus.out_ovf, 1);
    op(4'd9, 4'd8, 1'b0, 1'b0, 0);
    op(4'd15, 4'd0, 1'b1, 1'b0, 0);

    op(4'd0, 4'd1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      op(4'd1, 4'd15, 1'b0, 1'b1, 0);
      chk("acc_step", bus.out_sum, i + 2);
    end

    op(4'd6, 4'd7, 1'b1, 1'b0, 3);

    send(4'd2, 4'd3, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_rdy", bus.in_ready, 1);
    chk("mid_rst_sum", bus.out_sum, 0);
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op(4'd7, 4'd7, 1'b0, 1'b0, 0);
    op(4'd0, 4'd3, 1'b0, 1'b1, 0);
    chk("acc_after_rst", bus.out_sum, 14);

    send(4'd4, 4'd2, 1'b0, 1'b0);
    wait_res();
    @(negedge clk);
    drive(4'd5, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("done_hold_a", add_a, 4);
      chk("done_hold_b", add_b, 2);
      chk("done_rdy", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("done_idle", bus.in_ready, 1);
    chk("done_noacc_a", add_a, 4);
    @(negedge clk);
    bus.out_ready = 1'b0;
    model(4'd5, 4'd6, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("late_acc_a", add_a, 5);
    chk("late_acc_b", add_b, 6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_res();
    chk("late_sum", bus.out_sum, 11);
    release_res(0);

    for (int i = 0; i < 30; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom),
         1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
